// File: rtl/timer_regs_pkg.sv
// Register map, control bit positions and FSM state encoding
// shared by the interval-timer scheduler and anything that talks to the timer.
package timer_regs_pkg;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERL    = 3'd2;
    localparam logic [2:0] TMR_PERH    = 3'd3;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_W_STOP = 3'd1;
    localparam logic [2:0] ST_W_PERL = 3'd2;
    localparam logic [2:0] ST_W_PERH = 3'd3;
    localparam logic [2:0] ST_W_CTRL = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    localparam logic [2:0] ST_W_CLR  = 3'd6;
    localparam logic [2:0] ST_W_HALT = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        W_STOP = ST_W_STOP,
        W_PERL = ST_W_PERL,
        W_PERH = ST_W_PERH,
        W_CTRL = ST_W_CTRL,
        RUN    = ST_RUN,
        W_CLR  = ST_W_CLR,
        W_HALT = ST_W_HALT
    } state_t;

    // Build a control register value from its individual flag bits.
    function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                              input logic start, input logic stop);
        logic [15:0] w;
        w = '0;
        w[CTRL_ITO]   = ito;
        w[CTRL_CONT]  = cont;
        w[CTRL_START] = start;
        w[CTRL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/timer_tick_scheduler_if.sv
// Write-only Avalon-MM link between the scheduler (master) and the interval timer (slave),
// including the timer's level interrupt back to the master.
interface timer_tick_scheduler_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic        irq;

    modport master (output address, output chipselect, output write_n, output writedata,
                    input irq);
    modport slave  (input address, input chipselect, input write_n, input writedata,
                    output irq);

endinterface

// File: rtl/timer_tick_scheduler.sv
// Programs the interval timer from period/mode requests, services each timeout
// and turns it into a one-cycle tick plus a running tick count.
module timer_tick_scheduler
    import timer_regs_pkg::*;
#(
    parameter int TICK_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [31:0]            cfg_period,
    input  logic                   cfg_continuous,
    input  logic                   stop_req,
    timer_tick_scheduler_if.master tmr,
    output logic                   tick,
    output logic [TICK_W-1:0]      tick_count,
    output logic                   busy
);

    state_t      state;
    logic [31:0] period_q;
    logic        cont_q;
    logic        stop_pending;
    logic        handshake;
    logic [31:0] period_next;

    assign handshake   = cfg_valid & cfg_ready;
    // The timer counts period+1 cycles, and anything below a 2-cycle tick is clamped to it.
    assign period_next = (cfg_period < 32'd2) ? 32'd1 : (cfg_period - 32'd1);

    // Bus outputs are set on the edge entering a W_* state, so each write lines up with its state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            period_q       <= '0;
            cont_q         <= 1'b0;
            stop_pending   <= 1'b0;
            cfg_ready      <= 1'b1;
            busy           <= 1'b0;
            tick           <= 1'b0;
            tick_count     <= '0;
            tmr.address    <= TMR_STATUS;
            tmr.chipselect <= 1'b0;
            tmr.write_n    <= 1'b1;
            tmr.writedata  <= '0;
        end else begin
            tmr.chipselect <= 1'b0;
            tmr.write_n    <= 1'b1;
            tick           <= 1'b0;

            if (stop_req && state != IDLE) begin
                stop_pending <= 1'b1;
            end

            if (handshake) begin
                period_q       <= period_next;
                cont_q         <= cfg_continuous;
                tick_count     <= '0;
                stop_pending   <= 1'b0;
                state          <= W_STOP;
                cfg_ready      <= 1'b0;
                busy           <= 1'b1;
                tmr.chipselect <= 1'b1;
                tmr.write_n    <= 1'b0;
                tmr.address    <= TMR_CONTROL;
                tmr.writedata  <= ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                case (state)
                    IDLE: ;
                    W_STOP: begin
                        state          <= W_PERL;
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= TMR_PERL;
                        tmr.writedata  <= period_q[15:0];
                    end
                    W_PERL: begin
                        state          <= W_PERH;
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= TMR_PERH;
                        tmr.writedata  <= period_q[31:16];
                    end
                    W_PERH: begin
                        state          <= W_CTRL;
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= TMR_CONTROL;
                        tmr.writedata  <= ctrl_word(1'b1, cont_q, 1'b1, 1'b0);
                    end
                    W_CTRL: begin
                        state     <= RUN;
                        cfg_ready <= 1'b1;
                    end
                    RUN: begin
                        // A stop requested during programming is only honoured here, once the timer runs.
                        if (stop_pending) begin
                            state          <= W_HALT;
                            cfg_ready      <= 1'b0;
                            tmr.chipselect <= 1'b1;
                            tmr.write_n    <= 1'b0;
                            tmr.address    <= TMR_CONTROL;
                            tmr.writedata  <= ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
                        end else if (tmr.irq) begin
                            state          <= W_CLR;
                            cfg_ready      <= 1'b0;
                            tick           <= 1'b1;
                            tick_count     <= tick_count + 1'b1;
                            tmr.chipselect <= 1'b1;
                            tmr.write_n    <= 1'b0;
                            tmr.address    <= TMR_STATUS;
                            tmr.writedata  <= '0;
                        end
                    end
                    W_CLR: begin
                        state     <= cont_q ? RUN : IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= cont_q;
                    end
                    W_HALT: begin
                        state        <= IDLE;
                        stop_pending <= 1'b0;
                        cfg_ready    <= 1'b1;
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Bench for timer_tick_scheduler: directed vector table with a forced irq, then
// randomized reprogramming against an attached interval-timer model and a timing-formula reference.
module tb_timer_tick_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_valid;
    logic [31:0] cfg_period;
    logic        cfg_continuous;
    logic        stop_req;
    logic        forced_irq;
    logic        use_timer;
    logic        timer_to;

    logic        cfg_ready,  tick,  busy;
    logic [15:0] tick_count;
    logic        cfg_ready2, tick2, busy2;
    logic [1:0]  tick_count2;

    int vectors    = 0;
    int miscompares = 0;

    timer_tick_scheduler_if bus ();
    timer_tick_scheduler_if bus2 ();

    assign bus.irq  = use_timer ? timer_to : forced_irq;
    assign bus2.irq = use_timer ? timer_to : forced_irq;

    always #5 clk = ~clk;

    timer_tick_scheduler #(.TICK_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_continuous(cfg_continuous), .stop_req(stop_req),
        .tmr(bus), .tick(tick), .tick_count(tick_count), .busy(busy));

    timer_tick_scheduler #(.TICK_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
        .cfg_period(cfg_period), .cfg_continuous(cfg_continuous), .stop_req(stop_req),
        .tmr(bus2), .tick(tick2), .tick_count(tick_count2), .busy(busy2));

    // Interval timer: counts period..0, raises TO at zero (set beats a same-cycle clear).
    logic [31:0] tm_period, tm_cnt;
    logic        tm_run, tm_cont, tm_wr;
    assign tm_wr = bus.chipselect & ~bus.write_n;

    always @(posedge clk) begin
        if (!reset_n) begin
            tm_period <= '0; tm_cnt <= '0; tm_run <= 1'b0; tm_cont <= 1'b0; timer_to <= 1'b0;
        end else begin
            if (tm_wr && bus.address == 3'd0) timer_to <= 1'b0;
            if (tm_run) begin
                if (tm_cnt == 0) begin
                    timer_to <= 1'b1;
                    tm_cnt   <= tm_period;
                    if (!tm_cont) tm_run <= 1'b0;
                end else begin
                    tm_cnt <= tm_cnt - 1;
                end
            end
            if (tm_wr && bus.address == 3'd1) begin
                if (bus.writedata[3]) begin tm_run <= 1'b0; timer_to <= 1'b0; end
                if (bus.writedata[2]) begin
                    tm_run <= 1'b1; tm_cnt <= tm_period; tm_cont <= bus.writedata[1];
                end
            end
            if (tm_wr && bus.address == 3'd2) tm_period[15:0]  <= bus.writedata;
            if (tm_wr && bus.address == 3'd3) tm_period[31:16] <= bus.writedata;
        end
    end

    typedef struct {
        logic        valid;
        logic [31:0] period;
        logic        cont;
        logic        stop;
        logic        irq;
        logic        cs;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        tick;
        int          count;
        logic        busy;
        logic        ready;
    } vec_t;

    vec_t vecs[$];

    int unsigned script_p[4] = '{10, 3, 0, 1};
    bit          script_c[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int          script_h[4] = '{40, 40, 20, 20};

    function automatic vec_t mk(input logic v, input logic [31:0] p, input logic c, input logic s,
                                input logic i, input logic e_cs, input logic [2:0] e_addr,
                                input logic [15:0] e_data, input logic e_tick, input int e_count,
                                input logic e_busy, input logic e_ready);
        vec_t r;
        r.valid = v; r.period = p; r.cont = c; r.stop = s; r.irq = i;
        r.cs = e_cs; r.addr = e_addr; r.data = e_data; r.tick = e_tick; r.count = e_count;
        r.busy = e_busy; r.ready = e_ready;
        return r;
    endfunction

    task automatic checkField(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] p, input logic c,
                                 input logic s, input logic i);
        cfg_valid = v; cfg_period = p; cfg_continuous = c; stop_req = s; forced_irq = i;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic e_cs, input logic [2:0] e_addr,
                               input logic [15:0] e_data, input logic e_tick, input int e_count,
                               input logic e_busy, input logic e_ready);
        checkField({name, ".chipselect"}, bus.chipselect, e_cs);
        checkField({name, ".write_n"}, bus.write_n, !e_cs);
        if (e_cs) begin
            checkField({name, ".address"}, bus.address, e_addr);
            checkField({name, ".writedata"}, bus.writedata, e_data);
        end
        checkField({name, ".tick"}, tick, e_tick);
        checkField({name, ".tick_count"}, tick_count, e_count & 16'hFFFF);
        checkField({name, ".busy"}, busy, e_busy);
        checkField({name, ".cfg_ready"}, cfg_ready, e_ready);
        checkField({name, ".w2_tick_count"}, tick_count2, e_count & 3);
        checkField({name, ".w2_tick"}, tick2, e_tick);
        checkField({name, ".w2_chipselect"}, bus2.chipselect, e_cs);
        checkField({name, ".w2_busy"}, busy2, e_busy);
        checkField({name, ".w2_ready"}, cfg_ready2, e_ready);
    endtask

    task automatic checkReset(input string name);
        checkOutput(name, 1'b0, 3'd0, 16'h0, 1'b0, 0, 1'b0, 1'b1);
        checkField({name, ".address"}, bus.address, 0);
        checkField({name, ".writedata"}, bus.writedata, 0);
    endtask

    // Expected outputs of cycle c for a session accepted in cycle n0 with latched period p.
    function automatic void model_outputs(input bit have, input longint n0, input longint p,
                                          input bit mc, input longint c,
                                          output logic e_cs, output logic [2:0] e_addr,
                                          output logic [15:0] e_data, output logic e_tick,
                                          output int e_count, output logic e_busy,
                                          output logic e_ready);
        longint      rel, t0;
        logic [31:0] p32;
        e_cs = 1'b0; e_addr = 3'd0; e_data = 16'h0; e_tick = 1'b0; e_count = 0;
        e_busy = 1'b0; e_ready = 1'b1;
        if (have) begin
            rel = c - n0;
            t0  = 7 + p;
            p32 = p[31:0];
            e_busy = 1'b1; e_ready = 1'b0;
            if (rel == 1) begin e_cs = 1'b1; e_addr = 3'd1; e_data = 16'h0008; end
            else if (rel == 2) begin e_cs = 1'b1; e_addr = 3'd2; e_data = p32[15:0]; end
            else if (rel == 3) begin e_cs = 1'b1; e_addr = 3'd3; e_data = p32[31:16]; end
            else if (rel == 4) begin e_cs = 1'b1; e_addr = 3'd1; e_data = mc ? 16'h7 : 16'h5; end
            else begin
                if (rel >= t0) begin
                    if (mc) begin
                        e_count = int'((rel - t0) / (p + 1) + 1);
                        e_tick  = ((rel - t0) % (p + 1)) == 0;
                    end else begin
                        e_count = 1;
                        e_tick  = (rel == t0);
                    end
                end
                if (e_tick) begin
                    e_cs = 1'b1; e_addr = 3'd0; e_data = 16'h0;
                end else begin
                    e_ready = 1'b1;
                    e_busy  = mc || (rel < t0);
                end
            end
        end
    endfunction

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        e_cs, e_tick, e_busy, e_ready;
        logic [2:0]  e_addr;
        logic [15:0] e_data;
        int          e_count;
        bit          have, mc, req, rc, hs;
        longint      n0, mp, c;
        int unsigned rp;
        int          rh, hold, sessions;

        use_timer = 1'b0;
        reset_n   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkReset("reset");
        reset_n = 1'b1;

        applyStimulus(1, 32'd100, 1, 0, 0);
        checkOutput("abort.wstop", 1, 3'd1, 16'h0008, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("abort.wperl", 1, 3'd2, 16'd99, 0, 0, 1, 0);
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkReset("abort.reset");
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("abort.idle", 0, 3'd0, 16'h0, 0, 0, 0, 1);

        // valid period cont stop irq | cs addr data tick count busy ready
        vecs.push_back(mk(1, 32'h186A0, 1, 0, 0, 1, 1, 16'h0008, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 16'h869F, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 16'h0001, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 16'h0007, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 16'h0000, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 16'h0008, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 16'h0001, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 16'h0005, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 16'h0000, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 1));
        vecs.push_back(mk(1, 5, 1, 0, 0, 1, 1, 16'h0008, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 16'h0004, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 16'h0007, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 16'h0008, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3, 1, 1, 0, 1, 1, 16'h0008, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 16'h0002, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 16'h0007, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 16'h0008, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].period, vecs[i].cont, vecs[i].stop, vecs[i].irq);
            checkOutput($sformatf("vec%0d", i), vecs[i].cs, vecs[i].addr, vecs[i].data,
                        vecs[i].tick, vecs[i].count, vecs[i].busy, vecs[i].ready);
        end

        use_timer = 1'b1;
        have = 0; mc = 0; req = 0; rc = 0; n0 = 0; mp = 0; c = 0;
        rp = 0; rh = 0; hold = 0; sessions = 0;
        while ((sessions < 36 || c - n0 < 30) && c < 20000) begin
            model_outputs(have, n0, mp, mc, c, e_cs, e_addr, e_data, e_tick, e_count, e_busy, e_ready);
            checkOutput($sformatf("rand.c%0d", c), e_cs, e_addr, e_data, e_tick, e_count, e_busy, e_ready);
            if (!req && sessions < 36 && (!have || c - n0 >= hold)) begin
                req = 1;
                if (sessions < 4) begin
                    rp = script_p[sessions]; rc = script_c[sessions]; rh = script_h[sessions];
                end else begin
                    rc = 1'($urandom_range(0, 1));
                    rp = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 14);
                    rh = int'($urandom_range(3, 45));
                end
            end
            hs = req && e_ready;
            applyStimulus(req, rp, rc, 0, 0);
            if (hs) begin
                have = 1; n0 = c; mp = (rp < 2) ? 1 : longint'(rp) - 1; mc = rc;
                hold = rh; req = 0; sessions++;
            end
            c++;
        end
        if (c >= 20000) checkField("rand.cycle_budget", c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
